// File: rtl/au_add_pkg.sv
// rtl/au_add_pkg.sv - chunk geometry helpers and ARCH range shared by the pipelined adder
package au_add_pkg;

    localparam int ARCH_MIN = 0;
    localparam int ARCH_MAX = 2;

    function automatic int chunk_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int chunk_lo(input int k, input int cw);
        return k * cw;
    endfunction

    function automatic int chunk_hi(input int k, input int cw, input int width);
        return ((k + 1) * cw < width) ? (k + 1) * cw - 1 : width - 1;
    endfunction

endpackage

// File: rtl/au_add_c_pipe_stage.sv
// rtl/au_add_c_pipe_stage.sv - one chunk adder plus its stage register (AU_ADD_C_PIPE_OVF_EN adds ovf_o)
module au_add_c_pipe_stage
    import au_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int HI    = 3,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vld_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             vld_o,
    output logic             c_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o
`ifdef AU_ADD_C_PIPE_OVF_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int N = HI - LO + 1;

    logic [N-1:0] ca, cb, g, p, sum;
    logic [N:0]   cy;
    logic         gg, pp, c_out;

    // ARCH 0: ripple g/p chain; ARCH 1: group (G,P) prefix with carry-in applied last;
    // ARCH 2: behavioural add left to the synthesis tool.
    always_comb begin
        ca    = a_i[HI:LO];
        cb    = b_i[HI:LO];
        g     = ca & cb;
        p     = ca ^ cb;
        cy    = '0;
        cy[0] = c_i;
        gg    = 1'b0;
        pp    = 1'b1;
        for (int i = 0; i < N; i++) begin
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
            if (ARCH == 0) cy[i+1] = g[i] | (p[i] & cy[i]);
            else           cy[i+1] = gg | (pp & c_i);
        end
        if (ARCH == 2) begin
            {c_out, sum} = {1'b0, ca} + {1'b0, cb} + {{N{1'b0}}, c_i};
        end else begin
            sum   = p ^ cy[N-1:0];
            c_out = cy[N];
        end
    end

    logic             vld_q, vld_d, c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;

    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        if (en) begin
            vld_d        = vld_i;
            c_d          = c_out;
            a_d          = a_i;
            b_d          = b_i;
            s_d          = s_i;
            s_d[HI:LO]   = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign vld_o = vld_q;
    assign c_o   = c_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign s_o   = s_q;

`ifdef AU_ADD_C_PIPE_OVF_EN
    // Carry into the chunk MSB recovered from the sum bit, so it works for every ARCH.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (en) ovf_d = (sum[N-1] ^ ca[N-1] ^ cb[N-1]) ^ c_out;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/au_add_c_pipe.sv
// rtl/au_add_c_pipe.sv - pipelined chunked adder with carry-in/out and valid/ready (AU_ADD_C_PIPE_OVF_EN adds ovf)
module au_add_c_pipe
    import au_add_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int ARCH   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef AU_ADD_C_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = chunk_w(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || chunk_lo(STAGES - 1, CW) >= WIDTH) begin : g_bad_chunking
        $fatal(1, "au_add_c_pipe: WIDTH=%0d STAGES=%0d leaves an empty chunk", WIDTH, STAGES);
    end
    if (ARCH < ARCH_MIN || ARCH > ARCH_MAX) begin : g_bad_arch
        $fatal(1, "au_add_c_pipe: ARCH=%0d out of range", ARCH);
    end

    logic             en;
    logic             v_pipe [STAGES+1];
    logic             c_pipe [STAGES+1];
    logic [WIDTH-1:0] a_pipe [STAGES+1];
    logic [WIDTH-1:0] b_pipe [STAGES+1];
    logic [WIDTH-1:0] s_pipe [STAGES+1];

    // Global stall: every stage advances together, so holding the last stage holds all.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    assign v_pipe[0] = in_valid;
    assign c_pipe[0] = ci;
    assign a_pipe[0] = a;
    assign b_pipe[0] = b;
    assign s_pipe[0] = '0;

`ifdef AU_ADD_C_PIPE_OVF_EN
    logic ov_pipe [STAGES];
    assign ovf = ov_pipe[STAGES-1];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        au_add_c_pipe_stage #(
            .WIDTH (WIDTH),
            .LO    (chunk_lo(k, CW)),
            .HI    (chunk_hi(k, CW, WIDTH)),
            .ARCH  (ARCH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .vld_i (v_pipe[k]),
            .c_i   (c_pipe[k]),
            .a_i   (a_pipe[k]),
            .b_i   (b_pipe[k]),
            .s_i   (s_pipe[k]),
            .vld_o (v_pipe[k+1]),
            .c_o   (c_pipe[k+1]),
            .a_o   (a_pipe[k+1]),
            .b_o   (b_pipe[k+1]),
            .s_o   (s_pipe[k+1])
`ifdef AU_ADD_C_PIPE_OVF_EN
            ,
            .ovf_o (ov_pipe[k])
`endif
        );
    end

    assign out_valid = v_pipe[STAGES];
    assign s         = s_pipe[STAGES];
    assign co        = c_pipe[STAGES];

endmodule
